// File: rtl/pong_ball_engine_if.sv
// Frame-side control and renderer-side ball outputs of the pong ball engine.
// master: frame logic / bench; slave: the engine.
interface pong_ball_engine_if #(
  parameter int X_W = 9,
  parameter int Y_W = 8
);
  logic           tick;
  logic           go;
  logic           halt;
  logic [Y_W-1:0] paddle_l_y;
  logic [Y_W-1:0] paddle_r_y;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           moving;
  logic           score_l;
  logic           score_r;

  modport master (
    output tick, go, halt,
    output paddle_l_y, paddle_r_y,
    input  x, y, moving,
    input  score_l, score_r
  );

  modport slave (
    input  tick, go, halt,
    input  paddle_l_y, paddle_r_y,
    output x, y, moving,
    output score_l, score_r
  );
endinterface

// File: rtl/pong_ball_engine.sv
// Pong ball physics: serve countdown, wall/paddle bounce, scoring.
// Define PONG_SPEEDUP_EN to speed the ball up on every paddle hit.
module pong_ball_engine #(
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int X_MAX       = 319,
  parameter int Y_MAX       = 239,
  parameter int BALL_SIZE   = 4,
  parameter int PADDLE_H    = 32,
  parameter int PADDLE_X_L  = 20,
  parameter int PADDLE_X_R  = 299,
  parameter int VEL_W       = 4,
  parameter int VX_INIT     = 2,
  parameter int VY_INIT     = 1,
  parameter int SERVE_DELAY = 60
) (
  input logic clk,
  input logic reset,
  pong_ball_engine_if.slave bus
);
  localparam int XL = X_MAX - BALL_SIZE + 1;
  localparam int YL = Y_MAX - BALL_SIZE + 1;
  localparam int RX = PADDLE_X_R - BALL_SIZE;
  localparam int W  = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int CW = $clog2(SERVE_DELAY + 2);

  localparam logic signed [W-1:0] XL_S  = W'(XL);
  localparam logic signed [W-1:0] YL_S  = W'(YL);
  localparam logic signed [W-1:0] RX_S  = W'(RX);
  localparam logic signed [W-1:0] PXL_S = W'(PADDLE_X_L);
  localparam logic signed [W-1:0] BS_S  = W'(BALL_SIZE);
  localparam logic signed [W-1:0] PH_S  = W'(PADDLE_H);

  localparam logic [X_W-1:0] XC = X_W'(XL / 2);
  localparam logic [Y_W-1:0] YC = Y_W'(YL / 2);
  localparam logic [CW-1:0]  SD = CW'(SERVE_DELAY);

  localparam logic signed [VEL_W-1:0] VXI = VEL_W'(VX_INIT);
  localparam logic signed [VEL_W-1:0] VYI = VEL_W'(VY_INIT);

  typedef enum logic [1:0] {
    IDLE, SERVE, MOVE, SCORED
  } state_t;

  state_t state;

  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [CW-1:0]  cnt;
  logic           moving_q;
  logic           score_l_q;
  logic           score_r_q;

  logic signed [VEL_W-1:0] vx;
  logic signed [VEL_W-1:0] vy;

  logic signed [W-1:0] xs, ys;
  logic signed [W-1:0] vxs, vys;
  logic signed [W-1:0] nx, ny;
  logic signed [W-1:0] pl, pr;
  logic signed [W-1:0] y_nx;
  logic signed [VEL_W-1:0] vy_nx;
  logic signed [VEL_W-1:0] vx_bnc;
  logic signed [VEL_W-1:0] vx_srv;
  logic ovl_l, ovl_r;
  logic hit_l, hit_r;
  logic out_l, out_r;

  assign xs  = $signed(W'(x_q));
  assign ys  = $signed(W'(y_q));
  assign vxs = W'(vx);
  assign vys = W'(vy);
  assign nx  = xs + vxs;
  assign ny  = ys + vys;
  assign pl  = $signed(W'(bus.paddle_l_y));
  assign pr  = $signed(W'(bus.paddle_r_y));

  assign ovl_l = (ys + BS_S > pl) && (ys < pl + PH_S);
  assign ovl_r = (ys + BS_S > pr) && (ys < pr + PH_S);

  assign hit_l = vx[VEL_W-1] && (xs >= PXL_S)
               && (nx < PXL_S) && ovl_l;
  assign hit_r = !vx[VEL_W-1] && (vx != '0)
               && (xs <= RX_S) && (nx > RX_S) && ovl_r;
  assign out_l = !hit_l && !hit_r && (nx < 0);
  assign out_r = !hit_l && !hit_r && !out_l
               && (nx > XL_S);

  always_comb begin
    y_nx  = ny;
    vy_nx = vy;
    if (ny < 0) begin
      y_nx  = '0;
      vy_nx = -vy;
    end else if (ny > YL_S) begin
      y_nx  = YL_S;
      vy_nx = -vy;
    end
  end

`ifdef PONG_SPEEDUP_EN
  localparam logic [VEL_W-1:0] VMAX =
    VEL_W'((1 << (VEL_W - 1)) - 1);

  logic [VEL_W-1:0] mag;
  logic [VEL_W-1:0] mag_inc;

  assign mag     = vx[VEL_W-1] ? VEL_W'(-vx) : VEL_W'(vx);
  assign mag_inc = (mag >= VMAX) ? VMAX : mag + 1'b1;
  assign vx_bnc  = vx[VEL_W-1] ? $signed(mag_inc)
                              : -$signed(mag_inc);
  assign vx_srv  = vx[VEL_W-1] ? -VXI : VXI;
`else
  assign vx_bnc = -vx;
  assign vx_srv = vx;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      x_q       <= XC;
      y_q       <= YC;
      vx        <= VXI;
      vy        <= VYI;
      cnt       <= '0;
      moving_q  <= 1'b0;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
    end else if (bus.halt) begin
      state     <= IDLE;
      x_q       <= XC;
      y_q       <= YC;
      moving_q  <= 1'b0;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
    end else begin
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.go) begin
            state <= SERVE;
            cnt   <= SD;
            vx    <= vx_srv;
          end
        end
        SERVE: begin
          if (bus.tick) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            if (cnt <= CW'(1)) begin
              state    <= MOVE;
              moving_q <= 1'b1;
            end
          end
        end
        MOVE: begin
          if (bus.tick) begin
            if (out_l || out_r) begin
              // position freezes so the renderer shows the exit point
              state     <= SCORED;
              moving_q  <= 1'b0;
              score_r_q <= out_l;
              score_l_q <= out_r;
            end else begin
              y_q <= Y_W'(y_nx);
              vy  <= vy_nx;
              if (hit_l) begin
                x_q <= X_W'(PXL_S);
                vx  <= vx_bnc;
              end else if (hit_r) begin
                x_q <= X_W'(RX_S);
                vx  <= vx_bnc;
              end else begin
                x_q <= X_W'(nx);
              end
            end
          end
        end
        SCORED: begin
          state <= SERVE;
          cnt   <= SD;
          x_q   <= XC;
          y_q   <= YC;
          vx    <= score_l_q ? VXI : -VXI;
          vy    <= VYI;
        end
      endcase
    end
  end

  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.moving  = moving_q;
  assign bus.score_l = score_l_q;
  assign bus.score_r = score_r_q;
endmodule
